tt_um_ulriktj_sweep_ctrl: RTL and testbench

- Sweep/ramp controller for a 4-bit saturating up/down counter, packaged as a TinyTapeout top.
- Holds a small config bank (LOW, HIGH, DWELL, CTRL) written over ui_in.
- When run, sequences the counter as a triangle LOW→HIGH→LOW with programmable step rate and endpoint dwell, either continuous or single-shot.
- Counter value and status go to uo_out; FSM state goes to uio_out.

---
 rtl/sweep_pkg.sv | 30 +++
 rtl/sat_updown_counter.sv | 34 +++
 rtl/tt_um_ulriktj_sweep_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tt_um_ulriktj_sweep_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and constants for the sweep controller
package sweep_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_UP       = 3'd2,
        ST_DWELL_HI = 3'd3,
        ST_DOWN     = 3'd4,
        ST_DWELL_LO = 3'd5
    } state_t;

    localparam logic [1:0] SEL_LOW   = 2'd0;
    localparam logic [1:0] SEL_HIGH  = 2'd1;
    localparam logic [1:0] SEL_DWELL = 2'd2;
    localparam logic [1:0] SEL_CTRL  = 2'd3;

    localparam int CTRL_P_LSB  = 0;
    localparam int CTRL_P_MSB  = 1;
    localparam int CTRL_SINGLE = 2;
    localparam int CTRL_RSVD   = 3;

    localparam logic [WIDTH-1:0] RST_LOW   = 4'd0;
    localparam logic [WIDTH-1:0] RST_HIGH  = 4'd15;
    localparam logic [WIDTH-1:0] RST_DWELL = 4'd0;
    localparam logic [WIDTH-1:0] RST_CTRL  = 4'd0;

endpackage

// File: rtl/sat_updown_counter.sv
// rtl/sat_updown_counter.sv - loadable up/down counter that saturates at both ends
module sat_updown_counter
    import sweep_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [W-1:0] ONE     = W'(1);

    // load wins over stepping; steps stop at 0 and at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (up && count != MAX_VAL) begin
                count <= count + ONE;
            end else if (!up && count != '0) begin
                count <= count - ONE;
            end
        end
    end

endmodule

// File: rtl/tt_um_ulriktj_sweep_ctrl.sv
// rtl/tt_um_ulriktj_sweep_ctrl.sv - triangle sweep controller TinyTapeout top
module tt_um_ulriktj_sweep_ctrl
    import sweep_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_dwell;
    logic [WIDTH-1:0] r_ctrl;
    logic             r_wr_q;
    logic             r_cfg_err;
    logic [1:0]       r_presc;
    logic [WIDTH-1:0] r_dwell_cnt;
    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] w_count;
    logic             w_run;
    logic             w_wr_fire;
    logic [1:0]       w_p;
    logic             w_single;
    logic             w_at_high;
    logic             w_at_low;
    logic             w_tick;
    logic             w_cfg_ok;
    logic             w_load;
    logic             w_step_en;
    logic             w_up;
    logic             w_dir;
    logic             w_busy;
    logic             w_unused;

    assign w_run     = ui_in[7];
    assign w_wr_fire = ui_in[6] & ~r_wr_q & (r_state == ST_IDLE);
    assign w_p       = r_ctrl[CTRL_P_MSB:CTRL_P_LSB];
    assign w_single  = r_ctrl[CTRL_SINGLE];
    assign w_at_high = (w_count == r_high);
    assign w_at_low  = (w_count == r_low);
    assign w_tick    = (r_presc == w_p);
    assign w_cfg_ok  = (r_low < r_high);
    assign w_unused  = &{1'b0, ena, uio_in, r_ctrl[CTRL_RSVD]};

    sat_updown_counter #(.W(WIDTH)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (r_low),
        .en       (w_step_en),
        .up       (w_up),
        .count    (w_count)
    );

    // write strobe edge detect and config bank, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_q  <= 1'b0;
            r_low   <= RST_LOW;
            r_high  <= RST_HIGH;
            r_dwell <= RST_DWELL;
            r_ctrl  <= RST_CTRL;
        end else begin
            r_wr_q <= ui_in[6];
            if (w_wr_fire) begin
                case (ui_in[5:4])
                    SEL_LOW:   r_low   <= ui_in[3:0];
                    SEL_HIGH:  r_high  <= ui_in[3:0];
                    SEL_DWELL: r_dwell <= ui_in[3:0];
                    default:   r_ctrl  <= ui_in[3:0];
                endcase
            end
        end
    end

    // run request in idle either flags a bad window or clears the flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else if (r_state == ST_IDLE && w_run) begin
            r_cfg_err <= ~w_cfg_ok;
        end
    end

    // step prescaler runs only while ramping between endpoints
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 2'd0;
        end else if ((r_state == ST_UP && !w_at_high) || (r_state == ST_DOWN && !w_at_low)) begin
            r_presc <= w_tick ? 2'd0 : r_presc + 2'd1;
        end else begin
            r_presc <= 2'd0;
        end
    end

    // dwell counter loads on endpoint detect and counts down inside dwell states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_cnt <= '0;
        end else if ((r_state == ST_UP && w_at_high) || (r_state == ST_DOWN && w_at_low)) begin
            r_dwell_cnt <= r_dwell;
        end else if ((r_state == ST_DWELL_HI || r_state == ST_DWELL_LO) && r_dwell_cnt != '0) begin
            r_dwell_cnt <= r_dwell_cnt - WIDTH'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state; dropping run leaves any active state immediately
    always_comb begin
        w_next_state = r_state;
        if (r_state != ST_IDLE && !w_run) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (w_run && w_cfg_ok) w_next_state = ST_START;
                ST_START:    w_next_state = ST_UP;
                ST_UP:       if (w_at_high) w_next_state = ST_DWELL_HI;
                ST_DWELL_HI: if (r_dwell_cnt == '0) w_next_state = ST_DOWN;
                ST_DOWN:     if (w_at_low) w_next_state = ST_DWELL_LO;
                ST_DWELL_LO: if (r_dwell_cnt == '0) w_next_state = w_single ? ST_IDLE : ST_UP;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; counter moves only while run is held so a stop freezes it
    always_comb begin
        w_load    = 1'b0;
        w_step_en = 1'b0;
        w_up      = 1'b0;
        w_dir     = 1'b0;
        w_busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_START: begin
                w_load = w_run;
                w_dir  = 1'b1;
            end
            ST_UP: begin
                w_dir     = 1'b1;
                w_up      = 1'b1;
                w_step_en = w_run & ~w_at_high & w_tick;
            end
            ST_DWELL_HI: w_dir = 1'b1;
            ST_DOWN:     w_step_en = w_run & ~w_at_low & w_tick;
            default: ;
        endcase
    end

    // endpoint flags are qualified by busy so an idle block presents all zeros
    assign uo_out  = {w_busy, w_busy & w_at_low, w_busy & w_at_high, w_dir, w_count};
    assign uio_out = {4'b0000, r_cfg_err, r_state};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_ulriktj_sweep_ctrl.sv
// tb/tb_tt_um_ulriktj_sweep_ctrl.sv - directed self-checking bench for the sweep controller
module tb_tt_um_ulriktj_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    int total = 0;
    int bad   = 0;

    tt_um_ulriktj_sweep_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_field(input logic [1:0] sel, input logic [3:0] d);
        ui_in = {1'b0, 1'b1, sel, d};
        cyc();
        ui_in = 8'h00;
        cyc();
    endtask

    function automatic logic [7:0] exp_uo(input logic [2:0] st, input logic [3:0] c,
                                          input logic [3:0] lo, input logic [3:0] hi);
        logic busy;
        logic dir;
        busy = (st != 3'd0);
        dir  = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
        return {busy, busy && (c == lo), busy && (c == hi), dir, c};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        cyc(2);
        rst_n = 1'b1;
        total++;
        if (uio_oe !== 8'h0F) begin
            bad++;
            $display("FAIL reset_oe: got %h want 0f", uio_oe);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (uo_out !== 8'h00) begin
                bad++;
                $display("FAIL reset_uo cycle %0d: got %h want 00", i, uo_out);
            end
            total++;
            if (uio_out !== 8'h00) begin
                bad++;
                $display("FAIL reset_uio cycle %0d: got %h want 00", i, uio_out);
            end
        end
    endtask

    task automatic test_triangle();
        logic [2:0] st [10] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
        logic [3:0] cn [10] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd5, 4'd4, 4'd3, 4'd3};
        logic [7:0] e;
        write_field(2'd0, 4'd3);
        write_field(2'd1, 4'd6);
        write_field(2'd2, 4'd0);
        write_field(2'd3, 4'd0);
        ui_in = 8'h80;
        cyc();
        total++;
        if (uio_out !== 8'h01) begin
            bad++;
            $display("FAIL tri_start: got %h want 01", uio_out);
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            e = exp_uo(st[i % 10], cn[i % 10], 4'd3, 4'd6);
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("FAIL tri_uo step %0d: got %h want %h", i, uo_out, e);
            end
            total++;
            if (uio_out !== {5'b0, st[i % 10]}) begin
                bad++;
                $display("FAIL tri_state step %0d: got %h want %h", i, uio_out, {5'b0, st[i % 10]});
            end
        end
        ui_in = 8'h00;
        cyc();
        total++;
        if (uo_out !== 8'h03 || uio_out !== 8'h00) begin
            bad++;
            $display("FAIL tri_stop: got uo=%h uio=%h want uo=03 uio=00", uo_out, uio_out);
        end
    endtask

    task automatic test_single_shot();
        logic [2:0] st [17] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4,
                                3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd0};
        logic [3:0] cn [17] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
                                4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic [7:0] e;
        write_field(2'd3, 4'b0101);
        write_field(2'd0, 4'd0);
        write_field(2'd1, 4'd2);
        write_field(2'd2, 4'd2);
        ui_in = 8'h80;
        cyc();
        total++;
        if (uio_out !== 8'h01) begin
            bad++;
            $display("FAIL ss_start: got %h want 01", uio_out);
        end
        for (int i = 0; i < 17; i++) begin
            cyc();
            e = exp_uo(st[i], cn[i], 4'd0, 4'd2);
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("FAIL ss_uo step %0d: got %h want %h", i, uo_out, e);
            end
            total++;
            if (uio_out !== {5'b0, st[i]}) begin
                bad++;
                $display("FAIL ss_state step %0d: got %h want %h", i, uio_out, {5'b0, st[i]});
            end
        end
        ui_in = 8'h00;
        cyc();
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            bad++;
            $display("FAIL ss_idle: got uo=%h uio=%h want 00 00", uo_out, uio_out);
        end
    endtask

    task automatic test_cfg_err();
        write_field(2'd0, 4'd9);
        write_field(2'd1, 4'd9);
        ui_in = 8'h80;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++;
            if (uio_out !== 8'h08) begin
                bad++;
                $display("FAIL cfg_err_set %0d: got %h want 08", i, uio_out);
            end
            total++;
            if (uo_out !== 8'h00) begin
                bad++;
                $display("FAIL cfg_err_count %0d: got %h want 00", i, uo_out);
            end
        end
        write_field(2'd1, 4'd12);
        total++;
        if (uio_out !== 8'h08) begin
            bad++;
            $display("FAIL cfg_err_hold: got %h want 08", uio_out);
        end
        ui_in = 8'h80;
        cyc();
        total++;
        if (uio_out !== 8'h01) begin
            bad++;
            $display("FAIL cfg_err_clear: got %h want 01", uio_out);
        end
        cyc();
        total++;
        if (uo_out !== 8'hD9 || uio_out !== 8'h02) begin
            bad++;
            $display("FAIL cfg_err_rerun: got uo=%h uio=%h want d9 02", uo_out, uio_out);
        end
        ui_in = 8'h00;
        cyc();
    endtask

    task automatic test_stop_mid_down();
        write_field(2'd3, 4'd0);
        write_field(2'd2, 4'd0);
        write_field(2'd0, 4'd3);
        write_field(2'd1, 4'd6);
        ui_in = 8'h80;
        cyc();
        cyc(7);
        total++;
        if (uo_out !== 8'h85 || uio_out !== 8'h04) begin
            bad++;
            $display("FAIL stop_at_down5: got uo=%h uio=%h want 85 04", uo_out, uio_out);
        end
        ui_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++;
            if (uo_out !== 8'h05 || uio_out !== 8'h00) begin
                bad++;
                $display("FAIL stop_hold %0d: got uo=%h uio=%h want 05 00", i, uo_out, uio_out);
            end
        end
    endtask

    task automatic test_write_hold();
        ui_in = {1'b0, 1'b1, 2'd0, 4'd2};
        cyc();
        ui_in = {1'b0, 1'b1, 2'd0, 4'd4};
        cyc(3);
        ui_in = 8'h00;
        cyc();
        ui_in = 8'h80;
        cyc();
        cyc();
        total++;
        if (uo_out !== 8'hD2) begin
            bad++;
            $display("FAIL hold_write_low: got %h want d2", uo_out);
        end
        cyc();
        total++;
        if (uo_out !== 8'h93) begin
            bad++;
            $display("FAIL hold_write_step: got %h want 93", uo_out);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got uo=%h uio=%h want 00 00", uo_out, uio_out);
        end
        cyc();
        rst_n = 1'b1;
        ui_in = 8'h80;
        cyc();
        total++;
        if (uio_out !== 8'h01) begin
            bad++;
            $display("FAIL post_reset_start: got %h want 01", uio_out);
        end
        cyc();
        total++;
        if (uo_out !== 8'hD0) begin
            bad++;
            $display("FAIL post_reset_low: got %h want d0", uo_out);
        end
        cyc(15);
        total++;
        if (uo_out !== 8'hBF || uio_out !== 8'h02) begin
            bad++;
            $display("FAIL post_reset_high: got uo=%h uio=%h want bf 02", uo_out, uio_out);
        end
        cyc();
        total++;
        if (uio_out !== 8'h03) begin
            bad++;
            $display("FAIL post_reset_dwell: got %h want 03", uio_out);
        end
        cyc();
        total++;
        if (uio_out !== 8'h04) begin
            bad++;
            $display("FAIL post_reset_down: got %h want 04", uio_out);
        end
        ui_in = 8'h00;
        cyc();
    endtask

    initial begin
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        test_reset();
        test_triangle();
        test_single_shot();
        test_cfg_err();
        test_stop_mid_down();
        test_write_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
